hdc_bundle_encoder: RTL and testbench
=====================================

# hdc_bundle_encoder

Streaming hyperdimensional bundling encoder: accepts N sample hypervectors over a valid/ready stream, optionally binds each to a key hypervector by XOR, and accumulates per-dimension ones counts. It then thresholds each count into one encoded bit and presents the result on a valid/ready output. It replaces the fixed-threshold, free-running encoder in the HDC front end with a session-based, back-pressure-aware block that has selectable bind and threshold modes.

## Interface
- DIM, 64, hypervector width in bits (≥1)
- CNT_W, 8, width of sample count, threshold and per-dimension accumulators (≥2)
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; opens a session; honoured only in IDLE
- clr  in  1  synchronous abort; returns to IDLE from any state
- cfg_cnt  in  CNT_W  sample count N, latched on accepted start
- cfg_thre  in  CNT_W  manual threshold T, latched on accepted start
- cfg_mode  in  2  bit0 = bind enable, bit1 = auto threshold; latched on accepted start
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DIM  sample hypervector
- in_key  in  DIM  key hypervector, used only when bind is enabled
- out_valid  out  1  encoded vector valid
- out_ready  in  1  consumer accepts the encoded vector
- out_enc  out  DIM  encoded hypervector
- busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, ACC, THRESH, OUT.
- IDLE: start=1 latches cfg_*, clears all accumulators and the beat counter. Next state is ACC, or THRESH if N=0.
- ACC: in_ready=1. A beat is accepted on in_valid&in_ready.
  - Each accepted beat forms v = in_data ^ (bind ? in_key : 0) and increments acc[d] by v[d] for every d.
  - The beat counter increments. On the Nth beat, next state is THRESH.
- Accumulators cannot overflow: acc[d] ≤ N ≤ 2^CNT_W−1. No saturation logic.
- THRESH (one cycle): effective threshold Te = auto ? (N >> 1) : T. The block registers out_enc[d] = (acc[d] > Te), strict compare. Next state is OUT.
- With auto threshold this is a strict majority; for even N, ties give 0.
- OUT: out_valid=1, out_enc held stable. On out_ready=1, next state is IDLE.
- start outside IDLE is ignored; it is neither queued nor flagged.
- clr has priority over every other event, including a same-cycle handshake or start. Effects:
  - accumulators and beat counter cleared
  - out_valid dropped
  - out_enc zeroed
  - state set to IDLE
- in_ready=0 and out_valid=0 in every state not listed above.

## Timing
- Reset values: in_ready=0, out_valid=0, out_enc=0, busy=0, state IDLE, accumulators 0, latched cfg 0.
- in_ready rises in the cycle after the accepted start.
- If the last beat is accepted in cycle k, THRESH occurs in k+1 and out_valid=1 from k+2. Sample-to-result latency is 2 cycles.
- N=0: start in cycle s gives THRESH in s+1 and out_valid in s+2 with out_enc=0, since 0 > Te is false.
- out_valid, once high, stays high until out_ready or clr. out_enc does not change while out_valid=1.
- If out_ready=1 in the first OUT cycle, the vector is consumed in that cycle. A new start is accepted no earlier than the following cycle.
- in_ready does not depend combinationally on in_valid. out_valid does not depend combinationally on out_ready.
- Asynchronous reset mid-session discards the session entirely.

## Structure
- Package hdc_pkg holds:
  - state enum hdc_enc_state_e {IDLE, ACC, THRESH, OUT}
  - mode bit indices HDC_MODE_BIND=0 and HDC_MODE_AUTO=1
- Sub-module hdc_bit_acc: one per dimension, generated DIM times.
  - Ports: clk, rst_n, clr, en, one_bit, acc[CNT_W].
  - Behaviour: clears on clr, increments by one_bit when en.
  - The top drives clr = clr | accepted start, and en = accepted beat.

## Test plan
- DIM=8, N=3, bind off, manual T=1; beats 0xFF, 0x0F, 0x03 → out_enc=0x0F; out_valid 2 cycles after the 3rd beat.
- N=4, auto threshold (Te=2); beats 0xF0, 0xF0, 0xCC, 0x00 → counts 3,3,2,2,1,1,0,0 → out_enc=0xC0 (ties give 0).
- Bind on, N=1, in_data=0xAA, in_key=0xFF, T=0 → out_enc=0x55.
- Back-pressure: in_valid toggling every other cycle, and out_ready held low 5 cycles → same out_enc as unstalled; out_enc stable throughout; start pulses during ACC/OUT ignored.
- N=0 → out_valid 2 cycles after start, out_enc=0x00.
- clr asserted in ACC after 2 of 4 beats, then a fresh session N=1, data 0x01, T=0 → out_enc=0x01, no residue; async reset mid-OUT → all outputs 0 immediately.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared types for the HDC bundling encoder: FSM state encoding and mode bit positions.
package hdc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC    = 2'd1,
        THRESH = 2'd2,
        OUT    = 2'd3
    } hdc_enc_state_e;

    localparam int unsigned HDC_MODE_BIND = 0;
    localparam int unsigned HDC_MODE_AUTO = 1;

endpackage

// File: rtl/hdc_bit_acc.sv
// Per-dimension ones counter: cleared on clr, increments by one_bit on each enabled beat.
module hdc_bit_acc #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             one_bit,
    output logic [CNT_W-1:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(CNT_W-1){1'b0}}, one_bit};
        end
    end

endmodule

// File: rtl/hdc_bundle_encoder.sv
// Session-based HDC bundling encoder: optional XOR bind, per-dimension ones counts,
// strict-greater threshold (manual or N/2) and a held valid/ready result.
module hdc_bundle_encoder
    import hdc_pkg::*;
#(
    parameter int DIM   = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic [CNT_W-1:0] cfg_cnt,
    input  logic [CNT_W-1:0] cfg_thre,
    input  logic [1:0]       cfg_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIM-1:0]   in_data,
    input  logic [DIM-1:0]   in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIM-1:0]   out_enc,
    output logic             busy
);

    hdc_enc_state_e state, state_nxt;

    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            thre_q;
    logic [1:0]                  mode_q;
    logic [CNT_W-1:0]            beat_cnt;
    logic [CNT_W-1:0]            beat_cnt_inc;
    logic [DIM-1:0]              enc_q;
    logic [DIM-1:0]              enc_nxt;
    logic [DIM-1:0][CNT_W-1:0]   acc;
    logic [CNT_W-1:0]            te;

    logic start_acc;
    logic beat_acc;
    logic last_beat;
    logic acc_clr;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign out_enc   = enc_q;

    // clr wins over start and beats, so neither counts as accepted while it is high
    assign start_acc    = start && (state == IDLE) && !clr;
    assign beat_acc     = in_valid && in_ready && !clr;
    assign beat_cnt_inc = beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign last_beat    = beat_acc && (beat_cnt_inc == cnt_q);
    assign acc_clr      = clr || start_acc;

    assign te = mode_q[HDC_MODE_AUTO] ? (cnt_q >> 1) : thre_q;

    always_comb begin
        enc_nxt = '0;
        for (int unsigned d = 0; d < DIM; d++) begin
            enc_nxt[d] = (acc[d] > te);
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = (cfg_cnt == '0) ? THRESH : ACC;
                ACC:     if (last_beat) state_nxt = THRESH;
                THRESH:  state_nxt = OUT;
                OUT:     if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt_q    <= '0;
            thre_q   <= '0;
            mode_q   <= '0;
            beat_cnt <= '0;
            enc_q    <= '0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                beat_cnt <= '0;
                enc_q    <= '0;
            end else begin
                if (start_acc) begin
                    cnt_q    <= cfg_cnt;
                    thre_q   <= cfg_thre;
                    mode_q   <= cfg_mode;
                    beat_cnt <= '0;
                end else if (beat_acc) begin
                    beat_cnt <= beat_cnt_inc;
                end
                if (state == THRESH) begin
                    enc_q <= enc_nxt;
                end
            end
        end
    end

    for (genvar d = 0; d < DIM; d++) begin : g_acc
        hdc_bit_acc #(
            .CNT_W(CNT_W)
        ) u_acc (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (acc_clr),
            .en     (beat_acc),
            .one_bit(in_data[d] ^ (mode_q[HDC_MODE_BIND] & in_key[d])),
            .acc    (acc[d])
        );
    end

endmodule

// File: tb/tb_hdc_bundle_encoder.sv
// Bench for hdc_bundle_encoder at DIM=8: fixed vector table, clr/reset corner sequences,
// and randomized sessions checked against a per-dimension counting model.
module tb_hdc_bundle_encoder;

    localparam int DIM   = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             clr;
    logic [CNT_W-1:0] cfg_cnt;
    logic [CNT_W-1:0] cfg_thre;
    logic [1:0]       cfg_mode;
    logic             in_valid;
    logic             in_ready;
    logic [DIM-1:0]   in_data;
    logic [DIM-1:0]   in_key;
    logic             out_valid;
    logic             out_ready;
    logic [DIM-1:0]   out_enc;
    logic             busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] sd [256];
    logic [7:0] sk [256];

    always #5 clk = ~clk;

    hdc_bundle_encoder #(
        .DIM  (DIM),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clr      (clr),
        .cfg_cnt  (cfg_cnt),
        .cfg_thre (cfg_thre),
        .cfg_mode (cfg_mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_key   (in_key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_enc  (out_enc),
        .busy     (busy)
    );

    typedef struct {
        int          n;
        logic [7:0]  thre;
        logic [1:0]  mode;
        logic [31:0] d;
        logic [31:0] k;
        logic [7:0]  exp_enc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Count ones per dimension over the bound beats, then compare against the threshold.
    function automatic logic [7:0] model(input int n, input logic [7:0] thre, input logic [1:0] mode);
        logic [7:0] r;
        int cnt;
        int te;
        r  = '0;
        te = mode[1] ? (n / 2) : int'(thre);
        for (int d = 0; d < 8; d++) begin
            cnt = 0;
            for (int b = 0; b < n; b++) begin
                cnt += int'(((sd[b] ^ (mode[0] ? sk[b] : 8'h00)) >> d) & 8'h01);
            end
            r[d] = (cnt > te);
        end
        return r;
    endfunction

    task automatic run_session(input int n, input logic [7:0] thre, input logic [1:0] mode,
                               input bit gaps, input int stall, input bit pokes,
                               input logic [7:0] exp_enc);
        int  i;
        int  cyc;
        bit  take;
        start    = 1'b1;
        cfg_cnt  = n[7:0];
        cfg_thre = thre;
        cfg_mode = mode;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("in_ready_after_start", in_ready, (n != 0));
        // configuration must already be latched; scramble the inputs
        cfg_cnt  = 8'($urandom);
        cfg_thre = 8'($urandom);
        cfg_mode = 2'($urandom);
        i   = 0;
        cyc = 0;
        while (i < n && cyc < 4 * n + 20) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? sd[i] : 8'($urandom);
            in_key   = in_valid ? sk[i] : 8'($urandom);
            start    = pokes ? 1'($urandom_range(0, 1)) : 1'b0;
            take     = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (take) i++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (i < n) chk("beat_timeout", i, n);
        chk("out_valid_in_thresh", out_valid, 0);
        chk("in_ready_in_thresh", in_ready, 0);
        @(posedge clk); #1;
        chk("out_valid_latency", out_valid, 1);
        chk("out_enc", out_enc, exp_enc);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            start     = pokes ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            chk("out_valid_held", out_valid, 1);
            chk("out_enc_stable", out_enc, exp_enc);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_consume", out_valid, 0);
        chk("busy_after_consume", busy, 0);
    endtask

    task automatic to_out(input logic [7:0] d);
        start    = 1'b1;
        cfg_cnt  = 8'd1;
        cfg_thre = 8'd0;
        cfg_mode = 2'd0;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_key   = 8'h00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("to_out_valid", out_valid, 1);
        chk("to_out_enc", out_enc, d);
    endtask

    initial begin
        vec_t vt [7];
        logic [7:0] e;
        int n;

        vt[0] = '{n: 3, thre: 8'd1,   mode: 2'b00, d: 32'h00_03_0F_FF, k: 32'h0, exp_enc: 8'h0F};
        vt[1] = '{n: 4, thre: 8'd0,   mode: 2'b10, d: 32'h00_CC_F0_F0, k: 32'h0, exp_enc: 8'hC0};
        vt[2] = '{n: 1, thre: 8'd0,   mode: 2'b01, d: 32'h0000_00AA, k: 32'h0000_00FF, exp_enc: 8'h55};
        vt[3] = '{n: 0, thre: 8'd0,   mode: 2'b00, d: 32'h0, k: 32'h0, exp_enc: 8'h00};
        vt[4] = '{n: 3, thre: 8'd7,   mode: 2'b10, d: 32'h00_55_33_0F, k: 32'h0, exp_enc: 8'h17};
        vt[5] = '{n: 2, thre: 8'd0,   mode: 2'b11, d: 32'h0000_FF00, k: 32'h0000_F0F0, exp_enc: 8'h00};
        vt[6] = '{n: 2, thre: 8'd255, mode: 2'b00, d: 32'h0000_FFFF, k: 32'h0, exp_enc: 8'h00};

        rst_n = 1'b0; start = 1'b0; clr = 1'b0; cfg_cnt = '0; cfg_thre = '0; cfg_mode = '0;
        in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
        #13;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_enc", out_enc, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[v]) begin
            for (int b = 0; b < 4; b++) begin
                sd[b] = vt[v].d[8*b +: 8];
                sk[b] = vt[v].k[8*b +: 8];
            end
            run_session(vt[v].n, vt[v].thre, vt[v].mode, 1'b0, 0, 1'b0, vt[v].exp_enc);
        end

        // back-pressure on both sides plus ignored start pulses
        sd[0] = 8'hFF; sd[1] = 8'h0F; sd[2] = 8'h03;
        run_session(3, 8'd1, 2'b00, 1'b1, 5, 1'b1, 8'h0F);

        // clr after 2 of 4 beats, colliding with a beat and a start
        start = 1'b1; cfg_cnt = 8'd4; cfg_thre = 8'd0; cfg_mode = 2'b00;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 8'hFF; in_key = 8'h00;
        repeat (2) begin @(posedge clk); #1; end
        clr = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_in_ready", in_ready, 0);
        chk("clr_out_valid", out_valid, 0);
        sd[0] = 8'h01;
        run_session(1, 8'd0, 2'b00, 1'b0, 0, 1'b0, 8'h01);

        // clr during OUT beats a same-cycle out_ready and zeroes the result
        to_out(8'hA5);
        clr = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; out_ready = 1'b0;
        chk("clr_out_valid_out", out_valid, 0);
        chk("clr_out_enc_out", out_enc, 0);
        chk("clr_busy_out", busy, 0);

        // asynchronous reset mid-OUT
        to_out(8'h3C);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_enc", out_enc, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // randomized sessions against the counting model
        for (int r = 0; r < 25; r++) begin
            logic [7:0] th;
            logic [1:0] md;
            n  = $urandom_range(0, 12);
            th = 8'($urandom_range(0, n + 1));
            md = 2'($urandom);
            for (int b = 0; b < n; b++) begin
                sd[b] = 8'($urandom);
                sk[b] = 8'($urandom);
            end
            e = model(n, th, md);
            run_session(n, th, md, r[0], $urandom_range(0, 3), r[1], e);
        end

        // largest count the accumulators must hold without wrapping
        for (int b = 0; b < 255; b++) begin
            sd[b] = (b < 200) ? 8'hFF : 8'($urandom);
            sk[b] = 8'($urandom);
        end
        e = model(255, 8'd254, 2'b00);
        run_session(255, 8'd254, 2'b00, 1'b0, 0, 1'b0, e);
        e = model(255, 8'd0, 2'b10);
        run_session(255, 8'd0, 2'b10, 1'b0, 1, 1'b0, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
